spi_master: RTL and testbench

Mode-0 (CPOL=0, CPHA=0), MSB-first, 8-bit SPI master. It is the initiating end of the team's SPI bus and the counterpart of `SPI_slave_full`. It generates `sclk` and a per-byte `ss` frame from the system clock. It shifts a byte out on `mosi` while capturing a byte from `miso`, with a valid/ready handshake on the parallel side. It sits between on-chip logic that issues commands and an external or on-chip SPI slave.

---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_half_period_timer.sv | 33 +++
 rtl/spi_master.sv | 135 +++++++++++++
 tb/tb_spi_master.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions for the master and slave ends of the team SPI bus.
package spi_pkg;

    localparam int SPI_WORD_W = 8;

    // Mode 0: sclk idles low, data is sampled on the rising (leading) edge.
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_HIGH,
        ST_LOW,
        ST_TRAIL,
        ST_GAP
    } spi_master_state_t;

endpackage

// File: rtl/spi_half_period_timer.sv
// Loadable down-counter; done strobes for one cycle when a loaded count expires.
module spi_half_period_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt;
    logic             active;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            active <= 1'b0;
        end else if (load) begin
            cnt    <= load_val;
            active <= 1'b1;
        end else if (active) begin
            if (cnt == '0) begin
                active <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign done = active && (cnt == '0);

endmodule

// File: rtl/spi_master.sv
// Mode-0, MSB-first, single-byte SPI master with a valid/ready parallel side.
//
// state | meaning
// IDLE  | ss high, waiting for tx_valid
// LEAD  | ss low, first bit on mosi, waiting for first sclk rise
// HIGH  | sclk high, waiting for the falling edge
// LOW   | sclk low, next bit on mosi, waiting for the rising edge
// TRAIL | last falling edge done, holding ss low for one half period
// GAP   | ss high, enforcing the minimum idle time between frames
module spi_master
    import spi_pkg::*;
#(
    parameter int HALF_PERIOD    = 4,
    parameter int SS_IDLE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic [SPI_WORD_W-1:0] tx_data,
    output logic [SPI_WORD_W-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  sclk,
    output logic                  ss,
    output logic                  mosi,
    input  logic                  miso
);

    localparam int TMR_MAX = (HALF_PERIOD > SS_IDLE_CYCLES) ? HALF_PERIOD : SS_IDLE_CYCLES;
    localparam int TMR_W   = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX);
    localparam logic [TMR_W-1:0] H_LOAD = TMR_W'(HALF_PERIOD - 1);
    localparam logic [TMR_W-1:0] G_LOAD = (SS_IDLE_CYCLES > 0) ? TMR_W'(SS_IDLE_CYCLES - 1) : '0;

    spi_master_state_t     state;
    logic [2:0]            bit_cnt;
    logic [SPI_WORD_W-2:0] tx_sr;
    logic [SPI_WORD_W-1:0] rx_sr;
    logic                  accept;
    logic                  tmr_load;
    logic [TMR_W-1:0]      tmr_val;
    logic                  tmr_done;

    assign tx_ready = (state == ST_IDLE);
    assign busy     = (state != ST_IDLE);
    assign accept   = tx_valid && tx_ready;

    // The timer is reloaded on the same edge that enters each waiting state.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = H_LOAD;
        case (state)
            ST_IDLE:                   tmr_load = accept;
            ST_LEAD, ST_HIGH, ST_LOW:  tmr_load = tmr_done;
            ST_TRAIL: begin
                tmr_load = tmr_done && (SS_IDLE_CYCLES > 0);
                tmr_val  = G_LOAD;
            end
            default: tmr_load = 1'b0;
        endcase
    end

    spi_half_period_timer #(
        .CNT_W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            ss       <= 1'b1;
            sclk     <= SPI_CPOL;
            mosi     <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            bit_cnt  <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        tx_sr   <= tx_data[SPI_WORD_W-2:0];
                        mosi    <= tx_data[SPI_WORD_W-1];
                        ss      <= 1'b0;
                        bit_cnt <= '0;
                        state   <= ST_LEAD;
                    end
                end
                ST_LEAD, ST_LOW: begin
                    if (tmr_done) begin
                        sclk  <= ~SPI_CPOL;
                        rx_sr <= {rx_sr[SPI_WORD_W-2:0], miso};
                        state <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (tmr_done) begin
                        sclk <= SPI_CPOL;
                        if (bit_cnt == 3'd7) begin
                            state <= ST_TRAIL;
                        end else begin
                            mosi    <= tx_sr[SPI_WORD_W-2];
                            tx_sr   <= {tx_sr[SPI_WORD_W-3:0], 1'b0};
                            bit_cnt <= bit_cnt + 3'd1;
                            state   <= ST_LOW;
                        end
                    end
                end
                ST_TRAIL: begin
                    if (tmr_done) begin
                        ss       <= 1'b1;
                        rx_data  <= rx_sr;
                        rx_valid <= 1'b1;
                        mosi     <= 1'b0;
                        state    <= (SS_IDLE_CYCLES == 0) ? ST_IDLE : ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (tmr_done) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: default timing instance plus a fast H=1/G=0 instance.
module tb_spi_master;

    logic       clk = 1'b0;
    logic       rst;
    int         cyc = 0;
    int         total = 0;
    int         passed = 0;
    int         fails = 0;

    // default instance
    logic       tx_valid, tx_ready, rx_valid, busy, sclk, ss, mosi, miso;
    logic [7:0] tx_data, rx_data;
    // fast instance
    logic       f_tx_valid, f_tx_ready, f_rx_valid, f_busy, f_sclk, f_ss, f_mosi;
    logic [7:0] f_tx_data, f_rx_data;

    logic [1:0] sel;          // 0 loopback, 1 slave model, 2 constant
    logic       miso_const;
    logic [7:0] sl_pre;
    logic [7:0] sl_rx;
    logic [2:0] sl_idx;

    int         rises = 0;
    logic [7:0] mosi_bits = 8'h00;
    int         acc_q[$];
    int         f_acc_q[$];

    always #5 clk = ~clk;

    spi_master dut (
        .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .sclk(sclk), .ss(ss),
        .mosi(mosi), .miso(miso)
    );

    spi_master #(.HALF_PERIOD(1), .SS_IDLE_CYCLES(0)) dut_fast (
        .clk(clk), .rst(rst), .tx_valid(f_tx_valid), .tx_ready(f_tx_ready), .tx_data(f_tx_data),
        .rx_data(f_rx_data), .rx_valid(f_rx_valid), .busy(f_busy), .sclk(f_sclk), .ss(f_ss),
        .mosi(f_mosi), .miso(f_mosi)
    );

    assign miso = (sel == 2'd0) ? mosi : (sel == 2'd1) ? sl_pre[3'd7 - sl_idx] : miso_const;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && tx_valid && tx_ready)     acc_q.push_back(cyc);
        if (!rst && f_tx_valid && f_tx_ready) f_acc_q.push_back(cyc);
    end

    always @(posedge sclk) begin
        if (!ss) begin
            rises     <= rises + 1;
            mosi_bits <= {mosi_bits[6:0], mosi};
            sl_rx     <= {sl_rx[6:0], mosi};
        end
    end

    // Mode-0 slave: advances its output bit on each falling sclk, restarts when ss is high.
    always @(negedge sclk or posedge ss) begin
        if (ss) sl_idx <= 3'd0;
        else    sl_idx <= sl_idx + 3'd1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, output int acc);
        tx_data  = b;
        tx_valid = 1'b1;
        for (int i = 0; i < 200 && !tx_ready; i++) tick();
        check("send_ready", 32'(tx_ready), 32'd1);
        tick();
        acc      = cyc;
        tx_valid = 1'b0;
    endtask

    task automatic wait_rx(output int at, output logic [7:0] d);
        logic got;
        got = 1'b0;
        at  = 0;
        d   = 8'h00;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (rx_valid) begin
                got = 1'b1;
                at  = cyc;
                d   = rx_data;
                break;
            end
        end
        check("rx_timeout", 32'(got), 32'd1);
    endtask

    int         acc, at, r0, n0, gap, first_j, pulses;
    logic [7:0] d, rx1;
    logic [15:0] seq;

    initial begin
        rst = 1'b1;
        tx_valid = 1'b0; tx_data = 8'h00;
        f_tx_valid = 1'b0; f_tx_data = 8'h00;
        sel = 2'd0; miso_const = 1'b0; sl_pre = 8'h00;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // reset state
        check("rst_ss", 32'(ss), 32'd1);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_fast_ss_busy", {30'd0, f_ss, f_busy}, 32'd2);

        // loopback 0x5A
        r0 = rises;
        send(8'h5A, acc);
        check("lb_ss_low", 32'(ss), 32'd0);
        check("lb_busy", 32'(busy), 32'd1);
        check("lb_mosi_bit7", 32'(mosi), 32'd0);
        wait_rx(at, d);
        check("lb_rx_latency", 32'(at - acc), 32'd68);
        check("lb_rx_data", 32'(d), 32'h5A);
        check("lb_mosi_at_rises", 32'(mosi_bits), 32'h5A);
        check("lb_rise_count", 32'(rises - r0), 32'd8);
        tick();
        check("lb_rx_valid_pulse", 32'(rx_valid), 32'd0);

        // slave model exchange
        sel = 2'd1;
        sl_pre = 8'hA5;
        send(8'hCC, acc);
        wait_rx(at, d);
        check("sl_master_rx", 32'(d), 32'hA5);
        check("sl_slave_rx", 32'(sl_rx), 32'hCC);
        sl_pre = 8'h0F;
        send(8'hF0, acc);
        wait_rx(at, d);
        check("sl_master_rx2", 32'(d), 32'h0F);
        check("sl_slave_rx2", 32'(sl_rx), 32'hF0);

        // back-to-back 0xAA then 0x55
        sel = 2'd0;
        repeat (5) tick();
        n0 = acc_q.size();
        gap = 0;
        rx1 = 8'h00;
        tx_data = 8'hAA;
        tx_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (acc_q.size() == n0 + 1) begin
                tx_data = 8'h55;
                if (ss) gap++;
            end
            if (rx_valid) rx1 = rx_data;
            if (acc_q.size() >= n0 + 2) break;
        end
        tx_valid = 1'b0;
        check("b2b_accepts", 32'(acc_q.size() - n0), 32'd2);
        if (acc_q.size() >= n0 + 2)
            check("b2b_period", 32'(acc_q[n0 + 1] - acc_q[n0]), 32'd71);
        check("b2b_ss_gap", 32'(gap), 32'd3);
        check("b2b_rx1", 32'(rx1), 32'hAA);
        wait_rx(at, d);
        check("b2b_rx2", 32'(d), 32'h55);

        // reset after 4th sclk rise
        repeat (3) tick();
        r0 = rises;
        send(8'h96, acc);
        for (int i = 0; i < 100 && (rises - r0) < 4; i++) tick();
        check("abort_reached_4_rises", 32'(rises - r0), 32'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_ss", 32'(ss), 32'd1);
        check("abort_sclk", 32'(sclk), 32'd0);
        check("abort_mosi", 32'(mosi), 32'd0);
        check("abort_rx_valid", 32'(rx_valid), 32'd0);
        check("abort_rx_data", 32'(rx_data), 32'h00);
        check("abort_busy", 32'(busy), 32'd0);
        pulses = 0;
        for (int i = 0; i < 90; i++) begin
            tick();
            if (rx_valid) pulses++;
        end
        check("abort_no_rx_valid", 32'(pulses), 32'd0);
        send(8'h3C, acc);
        wait_rx(at, d);
        check("after_abort_rx", 32'(d), 32'h3C);
        check("after_abort_latency", 32'(at - acc), 32'd68);

        // miso forced high, mid-frame tx changes ignored
        sel = 2'd2;
        miso_const = 1'b1;
        n0 = acc_q.size();
        send(8'h81, acc);
        repeat (10) tick();
        tx_data = 8'h00;
        tx_valid = 1'b1;
        repeat (3) tick();
        tx_valid = 1'b0;
        tx_data = 8'hFF;
        wait_rx(at, d);
        check("miso1_rx", 32'(d), 32'hFF);
        check("miso1_mosi_unchanged", 32'(mosi_bits), 32'h81);
        check("miso1_no_extra_accept", 32'(acc_q.size() - n0), 32'd1);
        miso_const = 1'b0;
        send(8'h7E, acc);
        wait_rx(at, d);
        check("miso0_rx", 32'(d), 32'h00);
        check("miso0_mosi", 32'(mosi_bits), 32'h7E);

        // fast instance: H=1, G=0, loopback 0xC3
        n0 = f_acc_q.size();
        f_tx_data = 8'hC3;
        f_tx_valid = 1'b1;
        tick();
        check("fast_accept", 32'(f_acc_q.size() - n0), 32'd1);
        seq = 16'h0000;
        first_j = 0;
        rx1 = 8'h00;
        d = 8'h00;
        for (int j = 1; j <= 60; j++) begin
            tick();
            if (j <= 16) seq = {seq[14:0], f_sclk};
            if (f_rx_valid) begin
                if (first_j == 0) begin
                    first_j = j;
                    rx1 = f_rx_data;
                end else begin
                    d = f_rx_data;
                end
            end
            if (f_acc_q.size() >= n0 + 2) f_tx_valid = 1'b0;
        end
        f_tx_valid = 1'b0;
        check("fast_sclk_div2", 32'(seq), 32'hAAAA);
        check("fast_rx_latency", 32'(first_j), 32'd17);
        check("fast_rx1", 32'(rx1), 32'hC3);
        check("fast_rx2", 32'(d), 32'hC3);
        check("fast_accepts", 32'(f_acc_q.size() - n0), 32'd2);
        if (f_acc_q.size() >= n0 + 2)
            check("fast_period", 32'(f_acc_q[n0 + 1] - f_acc_q[n0]), 32'd18);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
